demux_credit_sched: RTL and testbench
=====================================

DEMUX_CREDIT_SCHED -- requirements
Module: demux_credit_sched

Interface
REQ-001 Parameter DW, default 32, flit data width in bits.
REQ-002 Parameter CRED, default 4, downstream buffer depth per output port (credits); legal range 1..15.
REQ-003 Parameter TO, default 255, blocked-cycle count that raises stall_alarm; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream offers a flit.
REQ-007 in_ready  output  1  scheduler accepts the flit this cycle.
REQ-008 in_data  input  DW  flit payload.
REQ-009 in_port  input  3  destination port code, 0..5 legal, 6..7 illegal.
REQ-010 credit_ret  input  6  one-hot-or-multi pulses; bit k returns one credit for port k.
REQ-011 dmx_valid  output  1  flit launched into the 1-to-6 demux this cycle; drives the demux din.
REQ-012 dmx_sel  output  3  demux select, equal to the destination port code.
REQ-013 dmx_data  output  DW  payload aligned with dmx_valid.
REQ-014 stall_alarm  output  1  head flit blocked for at least TO consecutive cycles.
REQ-015 err_port  output  1  one-cycle pulse when an illegal-port flit is dropped.
REQ-016 err_cred  output  1  sticky flag set on credit overflow.

Function
REQ-017 Single holding register (states EMPTY, HOLD); in_ready SHALL be 1 in EMPTY, and in HOLD only in the cycle the held flit fires.
REQ-018 Acceptance (in_valid & in_ready) SHALL load in_data/in_port into the holding register and enter HOLD; minimum latency acceptance-to-dmx_valid is 1 cycle.
REQ-019 Fire condition: HOLD and credit[hold_port] > 0; dmx_valid SHALL equal fire, combinational from registered state only (no in_* to dmx_* path).
REQ-020 dmx_sel and dmx_data SHALL reflect the held flit whenever in HOLD; when not firing, dmx_sel SHALL still be valid, and dmx_data may be any value.
REQ-021 On fire with no new acceptance: HOLD -> EMPTY; on fire with acceptance in the same cycle: remain HOLD with the new flit (back-to-back, one flit per cycle sustained).
REQ-022 An accepted flit with in_port 6 or 7 SHALL NOT enter HOLD; it is dropped, err_port pulses in the following cycle, and credits are untouched.
REQ-023 Six credit counters, width 4, each reset to CRED; fire to port k decrements credit[k] by 1.
REQ-024 credit_ret[k] increments credit[k] by 1; simultaneous fire to k and credit_ret[k] leaves credit[k] unchanged.
REQ-025 credit_ret[k] with credit[k] == CRED and no simultaneous fire to k: counter SHALL hold at CRED, and err_cred SHALL be set and remain set until reset.
REQ-026 A credit returned in cycle N SHALL be usable for firing in cycle N+1, not in cycle N.
REQ-027 Stall counter, 16 bits: cleared on fire or in EMPTY; increments each HOLD cycle without fire, saturating at TO; stall_alarm = (count == TO).
REQ-028 Flits SHALL leave strictly in acceptance order; there is no reordering or bypass.

Reset
REQ-029 rst_n low SHALL immediately force: state EMPTY, all credits = CRED, stall count 0, err_cred 0, err_port 0; outputs therefore in_ready 1, dmx_valid 0, stall_alarm 0.
REQ-030 A flit held when reset asserts SHALL be discarded; no dmx_valid SHALL occur while rst_n is low.
REQ-031 Reset deassertion is synchronised externally; the first acceptance is permitted on the first rising edge with rst_n high.

Structure
REQ-032 Port count (6), port-code width (3), credit-counter width (4) and illegal-port codes SHALL be constants in the shared NoC package.
REQ-033 One sub-module, credit_cnt (one instance per port: inc, dec, count, overflow), is natural; the demux tree itself stays outside this block.

Verification
REQ-034 Reset, then 4 flits to port 2 back-to-back with no credit_ret -> 4 dmx_valid pulses with sel=2 on consecutive cycles; 5th flit held, in_ready=0.
REQ-035 Continuing: credit_ret[2] pulse at cycle N -> 5th flit fires at cycle N+1, in_ready 1 that cycle.
REQ-036 Flit with in_port=7 -> no dmx_valid, err_port one-cycle pulse, credits all 4.
REQ-037 credit_ret=6'b111111 immediately after reset -> err_cred=1 and sticky; credits stay 4.
REQ-038 TO=8, port 0 credits exhausted, next flit held 8 cycles -> stall_alarm high from 8th blocked cycle; deasserts the cycle after the flit fires.
REQ-039 rst_n low mid-HOLD -> dmx_valid 0, in_ready 1 immediately; after release all credits = CRED, held flit never emitted.

Source files
------------

// File: rtl/demux_credit_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_credit_sched_pkg                                                     |
// | Shared constants, state encoding and port-legality helper for the          |
// | credit-based demux scheduler.                                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package demux_credit_sched_pkg;
  localparam int c_num_ports = 6;
  localparam int c_port_w    = 3;
  localparam int c_cred_w    = 4;
  localparam int c_stall_w   = 16;

  localparam logic [c_port_w-1:0] c_illegal_port_lo = 3'd6;
  localparam logic [c_port_w-1:0] c_illegal_port_hi = 3'd7;

  typedef enum logic [0:0] {
    st_empty = 1'b0,
    st_hold  = 1'b1
  } sched_state_t;

  function automatic logic port_is_illegal(input logic [c_port_w-1:0] port);
    return (port == c_illegal_port_lo) || (port == c_illegal_port_hi);
  endfunction
endpackage
`default_nettype wire

// File: rtl/demux_credit_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_credit_sched_if                                                      |
// | Upstream flit handshake, credit returns and demux launch bus.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface demux_credit_sched_if #(
  parameter int DW = 32
);
  import demux_credit_sched_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [DW-1:0]           in_data;
  logic [c_port_w-1:0]     in_port;
  logic [c_num_ports-1:0]  credit_ret;
  logic                    dmx_valid;
  logic [c_port_w-1:0]     dmx_sel;
  logic [DW-1:0]           dmx_data;

  modport master (
    output in_valid, in_data, in_port, credit_ret,
    input  in_ready, dmx_valid, dmx_sel, dmx_data
  );

  modport slave (
    input  in_valid, in_data, in_port, credit_ret,
    output in_ready, dmx_valid, dmx_sel, dmx_data
  );
endinterface
`default_nettype wire

// File: rtl/demux_credit_sched_credit_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_credit_sched_credit_cnt                                              |
// | Per-port credit counter, saturating at CRED with an overflow pulse.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module demux_credit_sched_credit_cnt
  import demux_credit_sched_pkg::*;
#(
  parameter int CRED = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                dec,
  output logic [c_cred_w-1:0] count,
  output logic                overflow
);
  localparam logic [c_cred_w-1:0] c_full = c_cred_w'(CRED);

  logic [c_cred_w-1:0] r_count;

  // Simultaneous inc and dec cancel, so a full counter may still take a return.
  assign overflow = inc && !dec && (r_count == c_full);
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= c_full;
    end else if (inc && !dec && (r_count != c_full)) begin
      r_count <= r_count + c_cred_w'(1);
    end else if (dec && !inc) begin
      r_count <= r_count - c_cred_w'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/demux_credit_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux_credit_sched                                                         |
// | Single-entry credit-gated scheduler feeding a 1-to-6 flit demux.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module demux_credit_sched
  import demux_credit_sched_pkg::*;
#(
  parameter int DW   = 32,
  parameter int CRED = 4,
  parameter int TO   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_credit_sched_if.slave  bus,
  output logic                 stall_alarm,
  output logic                 err_port,
  output logic                 err_cred
);
  localparam int                   c_sel_span = 1 << c_port_w;
  localparam logic [c_stall_w-1:0] c_to       = c_stall_w'(TO);

  sched_state_t           r_state;
  sched_state_t           w_state_nxt;
  logic [DW-1:0]          r_hold_data;
  logic [c_port_w-1:0]    r_hold_port;
  logic [c_stall_w-1:0]   r_stall_cnt;
  logic                   r_err_port;
  logic                   r_err_cred;

  logic [c_num_ports-1:0] w_dec;
  logic [c_num_ports-1:0] w_ovf;
  logic [c_cred_w-1:0]    w_credit [c_num_ports];
  logic [c_sel_span-1:0]  w_avail;
  logic                   w_fire;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_load;

  genvar k;
  generate
    for (k = 0; k < c_num_ports; k++) begin : g_credit
      demux_credit_sched_credit_cnt #(
        .CRED (CRED)
      ) u_credit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (bus.credit_ret[k]),
        .dec      (w_dec[k]),
        .count    (w_credit[k]),
        .overflow (w_ovf[k])
      );
      assign w_dec[k]   = w_fire && (r_hold_port == c_port_w'(k));
      assign w_avail[k] = (w_credit[k] != '0);
    end
    // Illegal codes never reach the holding register; pad them as unavailable.
    for (k = c_num_ports; k < c_sel_span; k++) begin : g_avail_pad
      assign w_avail[k] = 1'b0;
    end
  endgenerate

  always_comb begin
    w_fire      = 1'b0;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_state_nxt = r_state;

    w_fire   = (r_state == st_hold) && w_avail[r_hold_port];
    w_ready  = (r_state == st_empty) || w_fire;
    w_accept = bus.in_valid && w_ready;
    w_load   = w_accept && !port_is_illegal(bus.in_port);

    if (w_load) begin
      w_state_nxt = st_hold;
    end else if (w_fire) begin
      w_state_nxt = st_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= st_empty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data <= '0;
      r_hold_port <= '0;
    end else if (w_load) begin
      r_hold_data <= bus.in_data;
      r_hold_port <= bus.in_port;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_err_port  <= 1'b0;
      r_err_cred  <= 1'b0;
    end else begin
      if ((r_state != st_hold) || w_fire) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != c_to) begin
        r_stall_cnt <= r_stall_cnt + c_stall_w'(1);
      end
      r_err_port <= w_accept && port_is_illegal(bus.in_port);
      r_err_cred <= r_err_cred || (|w_ovf);
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.dmx_valid = w_fire;
  assign bus.dmx_sel   = r_hold_port;
  assign bus.dmx_data  = r_hold_data;
  assign stall_alarm   = (r_stall_cnt == c_to);
  assign err_port      = r_err_port;
  assign err_cred      = r_err_cred;
endmodule
`default_nettype wire

// File: tb/tb_demux_credit_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_demux_credit_sched                                                      |
// | Directed and randomized bench against a flit-queue/credit reference model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_demux_credit_sched;
  import demux_credit_sched_pkg::*;

  localparam int DW   = 32;
  localparam int CRED = 4;
  localparam int TO   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stall_alarm;
  logic err_port;
  logic err_cred;

  demux_credit_sched_if #(.DW(DW)) bus ();

  demux_credit_sched #(
    .DW   (DW),
    .CRED (CRED),
    .TO   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .stall_alarm (stall_alarm),
    .err_port    (err_port),
    .err_cred    (err_cred)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } flit_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    obs_fire = 0;
  flit_t q[$];
  int    cred[6];
  int    blocked;
  bit    m_err_cred;
  bit    m_err_port;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 6; k++) cred[k] = CRED;
    blocked    = 0;
    m_err_cred = 1'b0;
    m_err_port = 1'b0;
  endtask

  // One clock: drive at negedge, check just after, then advance the model to the edge.
  task automatic cycle(input bit v, input int port, input logic [DW-1:0] data,
                       input logic [5:0] cret);
    bit held, fire, ready, acc;
    int hp;
    @(negedge clk);
    bus.in_valid   = v;
    bus.in_port    = 3'(port);
    bus.in_data    = data;
    bus.credit_ret = cret;
    #1;
    held  = (q.size() > 0);
    hp    = held ? q[0].port : 0;
    fire  = held && (cred[hp] > 0);
    ready = !held || fire;
    acc   = v && ready;
    chk("in_ready", bus.in_ready, ready);
    chk("dmx_valid", bus.dmx_valid, fire);
    if (held) chk("dmx_sel", bus.dmx_sel, hp);
    if (fire) chk("dmx_data", bus.dmx_data, q[0].data);
    chk("stall_alarm", stall_alarm, (blocked == TO));
    chk("err_port", err_port, m_err_port);
    chk("err_cred", err_cred, m_err_cred);
    if (bus.dmx_valid === 1'b1) obs_fire++;

    for (int k = 0; k < 6; k++) begin
      int c;
      c = cred[k] - ((fire && hp == k) ? 1 : 0) + int'(cret[k]);
      if (c > CRED) begin
        c = CRED;
        m_err_cred = 1'b1;
      end
      cred[k] = c;
    end
    blocked = (held && !fire) ? ((blocked < TO) ? blocked + 1 : TO) : 0;
    if (fire) void'(q.pop_front());
    m_err_port = acc && (port >= 6);
    if (acc && port < 6) q.push_back('{port, data});
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.credit_ret = '0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_dmx_valid", bus.dmx_valid, 1'b0);
    chk("rst_stall_alarm", stall_alarm, 1'b0);
    chk("rst_err_cred", err_cred, 1'b0);
    chk("rst_err_port", err_port, 1'b0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_port  = 3'd0;
      #1;
      chk("rst_hold_dmx_valid", bus.dmx_valid, 1'b0);
      chk("rst_hold_in_ready", bus.in_ready, 1'b1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_port    = '0;
    bus.in_data    = '0;
    bus.credit_ret = '0;
    model_reset();
    do_reset();

    // Credit return on full counters right after reset: sticky overflow flag.
    cycle(0, 0, '0, 6'b111111);
    repeat (3) cycle(0, 0, '0, '0);
    do_reset();

    // Back-to-back flits to port 2 until credits run out.
    obs_fire = 0;
    for (int i = 0; i < 5; i++) cycle(1, 2, DW'($urandom), '0);
    repeat (2) cycle(0, 0, '0, '0);
    chk("b2b_pulses", obs_fire, 4);

    // A returned credit is usable the following cycle.
    cycle(1, 2, DW'($urandom), 6'b000100);
    cycle(0, 0, '0, '0);
    chk("ret_pulses", obs_fire, 5);
    repeat (4) cycle(0, 0, '0, 6'b000100);

    // Illegal destination is dropped.
    cycle(1, 7, DW'($urandom), '0);
    cycle(0, 0, '0, '0);
    cycle(1, 6, DW'($urandom), '0);
    repeat (2) cycle(0, 0, '0, '0);

    // Port 0 exhausted; held flit raises the stall alarm.
    for (int i = 0; i < 5; i++) cycle(1, 0, DW'($urandom), '0);
    repeat (10) cycle(0, 0, '0, '0);
    cycle(0, 0, '0, 6'b000001);
    repeat (3) cycle(0, 0, '0, '0);

    // Reset while a flit is held: it must never appear.
    for (int i = 0; i < 5; i++) cycle(1, 4, DW'($urandom), '0);
    cycle(0, 0, '0, '0);
    do_reset();
    obs_fire = 0;
    repeat (3) cycle(0, 0, '0, '0);
    chk("post_rst_no_emit", obs_fire, 0);
    for (int i = 0; i < 5; i++) cycle(1, 4, DW'($urandom), '0);
    repeat (2) cycle(0, 0, '0, '0);
    chk("post_rst_cred", obs_fire, 4);
    repeat (4) cycle(0, 0, '0, 6'b010000);

    // Randomized traffic with sparse credit returns and rare illegal ports.
    for (int n = 0; n < 1500; n++) begin
      bit            v;
      int            p;
      logic [5:0]    cr;
      v = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 15) == 0) ? 6 + int'($urandom_range(0, 1))
                                       : int'($urandom_range(0, 5));
      cr = '0;
      for (int k = 0; k < 6; k++)
        if (cred[k] < CRED && $urandom_range(0, 2) == 0) cr[k] = 1'b1;
      if (n > 1200 && $urandom_range(0, 49) == 0) cr[$urandom_range(0, 5)] = 1'b1;
      cycle(v, p, DW'($urandom), cr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
